// File: rtl/gauss_line_buffer_pkg.sv
// Shared definitions for the Gaussian line buffer: top-level state codes
// (common with mem_ctrl), line-buffer FSM encodings and a width helper.
package gauss_line_buffer_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GAUSSIAN = 3'd1;
    localparam logic [2:0] ST_END      = 3'd5;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_SCAN = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gauss_line_buffer_row_store.sv
// KSIZE-deep row shift register; row 0 is the oldest. The column mux picks
// one pixel from every held row to form a vertical column.
module gauss_row_store
    import gauss_line_buffer_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int PIX_W = 8,
    parameter int KSIZE = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       shift_en,
    input  logic [IMG_W*PIX_W-1:0]     row_in,
    input  logic [clog2(IMG_W)-1:0]    col,
    output logic [KSIZE*PIX_W-1:0]     column
);

    logic [IMG_W*PIX_W-1:0] rows [KSIZE];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < KSIZE; k++) begin
                rows[k] <= '0;
            end
        end else if (shift_en) begin
            for (int k = 0; k < KSIZE - 1; k++) begin
                rows[k] <= rows[k+1];
            end
            rows[KSIZE-1] <= row_in;
        end
    end

    always_comb begin
        column = '0;
        for (int k = 0; k < KSIZE; k++) begin
            column[k*PIX_W +: PIX_W] = rows[k][int'(col)*PIX_W +: PIX_W];
        end
    end

endmodule

// File: rtl/gauss_line_buffer.sv
// Sliding KSIZE-row window over a frame read row-by-row from SRAM, streamed
// to the Gaussian filter as vertical columns under valid/ready.
module gauss_line_buffer
    import gauss_line_buffer_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int PIX_W  = 8,
    parameter int KSIZE  = 5,
    parameter int RD_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2:0]                 state,
    output logic                       buffer_req,
    input  logic                       img_valid,
    input  logic [IMG_W*PIX_W-1:0]     img_data,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [KSIZE*PIX_W-1:0]     win_data,
    output logic [clog2(IMG_W)-1:0]    win_col,
    output logic [clog2(IMG_H)-1:0]    win_row,
    output logic                       frame_done
);

    localparam int CW = clog2(IMG_W);
    localparam int RW = clog2(IMG_H);
    localparam int LW = clog2(IMG_H + 1);
    localparam int WW = clog2(RD_LAT + 1);

    localparam logic [CW-1:0] LAST_COL   = CW'(IMG_W - 1);
    localparam logic [LW-1:0] ROWS_MAX   = LW'(IMG_H);
    localparam logic [LW-1:0] FILL_LAST  = LW'(KSIZE - 1);
    localparam logic [LW-1:0] ROW_OFFSET = LW'(1 + KSIZE / 2);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(RD_LAT);

    logic [2:0]    fsm;
    logic [WW-1:0] wait_cnt;
    logic [LW-1:0] rows_loaded;
    logic [CW-1:0] col;
    logic          armed;
    logic          abort;
    logic          capture;
    logic          handshake;

    // Column output: win_valid qualifies, win_ready accepts. A column is
    // consumed on a cycle with both high; while win_ready is low the column
    // and its coordinates stay unchanged.
    assign abort     = (fsm != S_IDLE) && ((state == ST_IDLE) || (state == ST_END));
    assign capture   = (fsm == S_WAIT) && (wait_cnt == WAIT_MAX) && img_valid && !abort;
    assign handshake = win_valid && win_ready;

    assign buffer_req = (fsm == S_REQ);
    assign win_valid  = (fsm == S_SCAN);
    assign frame_done = (fsm == S_DONE);
    assign win_col    = col;
    assign win_row    = win_valid ? RW'(rows_loaded - ROW_OFFSET) : '0;

    gauss_row_store #(
        .IMG_W (IMG_W),
        .PIX_W (PIX_W),
        .KSIZE (KSIZE)
    ) u_row_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (capture),
        .row_in   (img_data),
        .col      (col),
        .column   (win_data)
    );

    // A finished frame must not restart until the top level leaves ST_GAUSSIAN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed <= 1'b1;
        end else if (state != ST_GAUSSIAN) begin
            armed <= 1'b1;
        end else if (fsm == S_DONE) begin
            armed <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm         <= S_IDLE;
            wait_cnt    <= '0;
            rows_loaded <= '0;
            col         <= '0;
        end else if (abort) begin
            fsm         <= S_IDLE;
            wait_cnt    <= '0;
            rows_loaded <= '0;
            col         <= '0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    wait_cnt    <= '0;
                    rows_loaded <= '0;
                    col         <= '0;
                    if ((state == ST_GAUSSIAN) && armed) begin
                        fsm <= S_REQ;
                    end
                end
                S_REQ: begin
                    wait_cnt <= WW'(1);
                    fsm      <= S_WAIT;
                end
                S_WAIT: begin
                    // Count saturates at the capture point so a late img_valid is still taken.
                    if (capture) begin
                        rows_loaded <= rows_loaded + LW'(1);
                        wait_cnt    <= '0;
                        if (rows_loaded < FILL_LAST) begin
                            fsm <= S_REQ;
                        end else begin
                            fsm <= S_SCAN;
                            col <= '0;
                        end
                    end else if (wait_cnt != WAIT_MAX) begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_SCAN: begin
                    if (handshake) begin
                        if (col == LAST_COL) begin
                            col <= '0;
                            fsm <= (rows_loaded < ROWS_MAX) ? S_REQ : S_DONE;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    fsm <= S_IDLE;
                end
                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gauss_line_buffer.sv
// Directed bench for gauss_line_buffer: SRAM row responder, column scoreboard
// built from the frame geometry, and frame-level pulse counters.
module tb_gauss_line_buffer;
    import gauss_line_buffer_pkg::*;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 6;
    localparam int PIX_W  = 8;
    localparam int KSIZE  = 3;
    localparam int RD_LAT = 2;
    localparam int CW     = clog2(IMG_W);
    localparam int RW     = clog2(IMG_H);
    localparam int DW     = KSIZE * PIX_W;
    localparam int EW     = RW + CW + DW;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [2:0]             state;
    logic                   buffer_req;
    logic                   img_valid;
    logic [IMG_W*PIX_W-1:0] img_data;
    logic                   win_valid;
    logic                   win_ready;
    logic [DW-1:0]          win_data;
    logic [CW-1:0]          win_col;
    logic [RW-1:0]          win_row;
    logic                   frame_done;

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];

    int req_cnt    = 0;
    int hs_cnt     = 0;
    int done_cnt   = 0;
    int cyc        = 0;
    int last_req   = -1;
    int resp_row   = 0;
    int stall_row  = -1;
    int ready_mode = 0;
    int ready_ph   = 0;
    logic [EW-1:0] last_hs = '0;

    gauss_line_buffer #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .PIX_W  (PIX_W),
        .KSIZE  (KSIZE),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .state      (state),
        .buffer_req (buffer_req),
        .img_valid  (img_valid),
        .img_data   (img_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .win_col    (win_col),
        .win_row    (win_row),
        .frame_done (frame_done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total = total + 1;
        if (act !== expv) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [PIX_W-1:0] pix(input int r, input int c);
        return PIX_W'(r * 16 + c);
    endfunction

    function automatic logic [IMG_W*PIX_W-1:0] row_word(input int r);
        logic [IMG_W*PIX_W-1:0] w;
        w = '0;
        for (int c = 0; c < IMG_W; c++) begin
            w[c*PIX_W +: PIX_W] = pix(r, c);
        end
        return w;
    endfunction

    // Every window centre from the first full window to the last, every column in order.
    task automatic build_model();
        exp_q.delete();
        for (int r = KSIZE / 2; r <= IMG_H - 1 - KSIZE / 2; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                logic [DW-1:0] d;
                d = '0;
                for (int k = 0; k < KSIZE; k++) begin
                    d[k*PIX_W +: PIX_W] = pix(r - KSIZE / 2 + k, c);
                end
                exp_q.push_back({RW'(r), CW'(c), d});
            end
        end
    endtask

    // ---------------- SRAM responder ----------------
    // Junk with img_valid high one cycle early, then the real row RD_LAT cycles after the request.
    always begin
        @(negedge clk);
        if (buffer_req === 1'b1) begin
            @(posedge clk);
            #1;
            img_valid = 1'b1;
            img_data  = '1;
            repeat (RD_LAT - 1) @(posedge clk);
            #1;
            if (resp_row == stall_row) begin
                img_valid = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
            img_valid = 1'b1;
            img_data  = row_word(resp_row);
            resp_row  = resp_row + 1;
            @(posedge clk);
            #1;
            img_valid = 1'b0;
            img_data  = '0;
        end
    end

    // ---------------- ready driver ----------------
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            win_ready = 1'b1;
        end else begin
            win_ready = (ready_ph == 0) || (ready_ph == 3);
            ready_ph  = (ready_ph + 1) % 4;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n === 1'b1) begin
            if (buffer_req === 1'b1) begin
                if (last_req >= 0) begin
                    check("req_spacing", 64'((cyc - last_req) >= RD_LAT + 1), 64'd1);
                end
                last_req = cyc;
                req_cnt  = req_cnt + 1;
            end
            if (win_valid === 1'b1 && win_ready === 1'b1) begin
                hs_cnt  = hs_cnt + 1;
                last_hs = {win_row, win_col, win_data};
            end
            if (frame_done === 1'b1) begin
                done_cnt = done_cnt + 1;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && win_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("extra_column", 64'd1, 64'd0);
            end else if (win_ready === 1'b1) begin
                check("column", 64'({win_row, win_col, win_data}), 64'(exp_q[0]));
                void'(exp_q.pop_front());
            end else begin
                check("column_held", 64'({win_row, win_col, win_data}), 64'(exp_q[0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_frame(input int stall, input int mode);
        state = ST_IDLE;
        repeat (2) @(posedge clk);
        #1;
        resp_row   = 0;
        stall_row  = stall;
        ready_mode = mode;
        ready_ph   = 0;
        req_cnt    = 0;
        hs_cnt     = 0;
        done_cnt   = 0;
        build_model();
        state = ST_GAUSSIAN;
    endtask

    task automatic finish_frame(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 2000) begin
            @(negedge clk);
            n = n + 1;
        end
        check({tag, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
        // state stays ST_GAUSSIAN: no restart and no second pulse allowed
        repeat (6) @(negedge clk);
        check({tag, "_req_count"}, 64'(req_cnt), 64'(IMG_H));
        check({tag, "_hs_count"}, 64'(hs_cnt), 64'((IMG_H - KSIZE + 1) * IMG_W));
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_buffer_req"}, 64'(buffer_req), 64'd0);
        check({tag, "_win_valid"}, 64'(win_valid), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        check({tag, "_win_col"}, 64'(win_col), 64'd0);
        check({tag, "_win_row"}, 64'(win_row), 64'd0);
        check({tag, "_win_data"}, 64'(win_data), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst_n     = 1'b0;
        state     = ST_IDLE;
        img_valid = 1'b0;
        img_data  = '0;
        win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset");

        // Frame 1: free-flowing output, first and last columns pinned by hand.
        start_frame(-1, 0);
        check("model_first", 64'(exp_q[0]), 64'({3'd1, 3'd0, 24'h201000}));
        check("model_last", 64'(exp_q[$]), 64'({3'd4, 3'd7, 24'h574737}));
        check("model_len", 64'(exp_q.size()), 64'd32);
        n = 0;
        while (win_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        check("first_valid_seen", 64'(win_valid), 64'd1);
        check("first_win_row", 64'(win_row), 64'd1);
        check("first_win_col", 64'(win_col), 64'd0);
        check("first_win_data", 64'(win_data), 64'h201000);
        check("first_req_count", 64'(req_cnt), 64'd3);
        finish_frame("f1");
        check("f1_last_column", 64'(last_hs), 64'({3'd4, 3'd7, 24'h574737}));

        // Frame 2: 1-0-0-1 backpressure and a 3-cycle data stall on row 4.
        start_frame(4, 1);
        finish_frame("f2");

        // Frame 3: abort with ST_END at column 3 of the first window.
        start_frame(-1, 0);
        n = 0;
        while (!(win_valid === 1'b1 && win_col == 3) && n < 300) begin
            @(negedge clk);
            n = n + 1;
        end
        check("abort_point_seen", 64'(win_valid), 64'd1);
        state = ST_END;
        @(negedge clk);
        check("abort_win_valid", 64'(win_valid), 64'd0);
        check("abort_buffer_req", 64'(buffer_req), 64'd0);
        repeat (8) @(negedge clk);
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_req_count", 64'(req_cnt), 64'd3);
        exp_q.delete();

        // Frame 4: restart after abort must begin from an empty window.
        start_frame(-1, 0);
        finish_frame("f4");

        // Reset during the first S_WAIT of a new frame.
        start_frame(-1, 0);
        exp_q.delete();
        n = 0;
        while (buffer_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n = n + 1;
        end
        check("rst_req_seen", 64'(buffer_req), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        state = ST_IDLE;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("midreset");
        repeat (6) @(negedge clk);
        check("midreset_no_req", 64'(req_cnt), 64'd1);

        // Frame 5: clean frame after the mid-fill reset.
        start_frame(-1, 0);
        finish_frame("f5");

        state = ST_IDLE;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
